alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter ALU_LAT, default 1, cycles from operand drive to valid alu_result (1..4).
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  command FIFO not full.
REQ-007 cmd_op  in  3  0 AND, 1 OR, 2 XOR, 3 NOT, 4 ADD, 5 SUB, 6 MULT, 7 reserved.
REQ-008 cmd_load  in  1  1 = operand A from cmd_a; 0 = chain on previous result.
REQ-009 cmd_a, cmd_b  in  8 each  operands A and B.
REQ-010 alu_on  out  1  ALU enable.
REQ-011 alu_in_selector  out  3  one-hot {persist, load, reset}, bit2..bit0.
REQ-012 alu_num1, alu_num2  out  8 each  ALU operands.
REQ-013 alu_out_selector  out  7  one-hot {and, or, not, xor, add, sub, mult}, bit6..bit0.
REQ-014 alu_result  in  8  ALU output value.
REQ-015 alu_overflow  in  1  ALU multiply overflow.
REQ-016 res_valid  out  1; res_ready  in  1; res_data  out  8; res_err  out  1  result channel.

Function
REQ-017 Command transfer SHALL occur on a cycle with cmd_valid=1 and cmd_ready=1; cmd_ready SHALL be 0 exactly when DEPTH entries are held.
REQ-018 FIFO SHALL be first-in first-out; pointers SHALL wrap modulo DEPTH; a push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-019 cmd_op=7 SHALL be accepted, executed as no ALU op, and return res_data=0, res_err=1.
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT, HOLD.
REQ-021 IDLE->ISSUE when FIFO non-empty; head is popped on that transition and latched.
REQ-022 ISSUE (1 cycle): drive alu_num1 = cmd_a if load else accumulator, alu_num2 = cmd_b, alu_in_selector = load if cmd_load else persist, alu_out_selector from op; ->WAIT.
REQ-023 WAIT SHALL last ALU_LAT cycles, operands held stable, then capture alu_result into accumulator and res_data, res_err = alu_overflow AND op==MULT; ->HOLD.
REQ-024 HOLD: res_valid=1, res_data/res_err stable until res_ready=1; on handshake ->ISSUE if FIFO non-empty (pop), else IDLE.
REQ-025 Back-to-back commands SHALL complete at one result per ALU_LAT+2 cycles when res_ready is held 1.
REQ-026 Outside ISSUE/WAIT alu_in_selector SHALL be persist and alu_out_selector SHALL be 0.
REQ-027 alu_on SHALL be 1 from the first cycle after reset release onward.
REQ-028 Arithmetic is performed by the ALU only; accumulator SHALL store the 8-bit result, discarding wider bits.
REQ-029 Chaining (cmd_load=0) with no prior result since reset SHALL use accumulator value 0.

Reset
REQ-030 While rst=0: FSM IDLE, FIFO empty, accumulator 0, cmd_ready 0, res_valid 0, res_data 0, res_err 0, alu_on 0, alu_in_selector reset (3'b001), alu_num1/num2 0, alu_out_selector 0.
REQ-031 Reset asserted mid-operation SHALL discard in-flight and queued commands with no result emitted.
REQ-032 cmd_ready SHALL rise the first clock edge after rst deasserts.

Structure
REQ-033 Opcode encodings, FSM state encodings, in_selector and out_selector one-hot constants SHALL live in a shared ALU package.
REQ-034 Command FIFO SHALL be one sub-module, cmd_fifo, parameterised by DEPTH and width 20.

Verification
REQ-035 Load ADD a=8'h05 b=8'h03, res_ready=1 -> res_data=8'h08, res_err=0, alu_out_selector=7'b0000100 during ISSUE.
REQ-036 Load MULT a=8'h20 b=8'h10 with ALU model asserting overflow -> res_err=1; then chained SUB b=8'h01 -> num1 equals prior res_data.
REQ-037 Push 5 commands with res_ready=0, DEPTH=4 -> cmd_ready=0 after 5th accepted (1 popped + 4 queued); release res_ready -> 5 results in order.
REQ-038 res_ready held 0 for 10 cycles -> res_valid stays 1, res_data unchanged, no alu_in_selector=load pulses.
REQ-039 Drop rst during WAIT with 2 queued -> all outputs at reset values immediately; after release no res_valid without new commands.
REQ-040 cmd_op=7 -> res_data=0, res_err=1, alu_out_selector stays 0.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// rtl/alu_op_sequencer_pkg.sv - opcode, state, selector and command encodings for the ALU op sequencer
package alu_op_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NOT  = 3'd3,
    OP_ADD  = 3'd4,
    OP_SUB  = 3'd5,
    OP_MULT = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  localparam logic [2:0] IN_PERSIST = 3'b100;
  localparam logic [2:0] IN_LOAD    = 3'b010;
  localparam logic [2:0] IN_RESET   = 3'b001;

  localparam logic [6:0] OUT_AND  = 7'b1000000;
  localparam logic [6:0] OUT_OR   = 7'b0100000;
  localparam logic [6:0] OUT_NOT  = 7'b0010000;
  localparam logic [6:0] OUT_XOR  = 7'b0001000;
  localparam logic [6:0] OUT_ADD  = 7'b0000100;
  localparam logic [6:0] OUT_SUB  = 7'b0000010;
  localparam logic [6:0] OUT_MULT = 7'b0000001;
  localparam logic [6:0] OUT_NONE = 7'b0000000;

  localparam int CMD_W = 20;

  typedef struct packed {
    op_e        op;
    logic       load;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  function automatic logic [6:0] out_sel_of(input op_e op);
    case (op)
      OP_AND:  return OUT_AND;
      OP_OR:   return OUT_OR;
      OP_XOR:  return OUT_XOR;
      OP_NOT:  return OUT_NOT;
      OP_ADD:  return OUT_ADD;
      OP_SUB:  return OUT_SUB;
      OP_MULT: return OUT_MULT;
      default: return OUT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - show-ahead command FIFO, power-of-two depth, wrapping pointers
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - queues ALU commands and sequences operand drive, wait and result hand-off
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic       cmd_load,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic       alu_on,
  output logic [2:0] alu_in_selector,
  output logic [7:0] alu_num1,
  output logic [7:0] alu_num2,
  output logic [6:0] alu_out_selector,
  input  logic [7:0] alu_result,
  input  logic       alu_overflow,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_err
);

  state_e     state, state_next;
  cmd_t       cur;
  logic [7:0] acc;
  logic [1:0] wait_cnt;
  logic       running;
  logic       pop, capture, drive;
  logic       fifo_full, fifo_empty;
  logic [CMD_W-1:0] fifo_rdata;

  assign cmd_ready = running && !fifo_full;
  assign alu_on    = running;
  assign res_valid = (state == S_HOLD);

  cmd_fifo #(.DEPTH(DEPTH), .WIDTH(CMD_W)) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && cmd_ready),
    .wdata ({cmd_op, cmd_load, cmd_a, cmd_b}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next       = state;
    pop              = 1'b0;
    capture          = 1'b0;
    drive            = (state == S_ISSUE) || (state == S_WAIT);
    alu_in_selector  = running ? IN_PERSIST : IN_RESET;
    alu_out_selector = OUT_NONE;
    alu_num1         = 8'h00;
    alu_num2         = 8'h00;

    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        if (wait_cnt == 2'(ALU_LAT - 1)) begin
          capture    = 1'b1;
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          pop        = !fifo_empty;
          state_next = fifo_empty ? S_IDLE : S_ISSUE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Operands and selectors stay put for the whole ISSUE..WAIT window.
    if (drive) begin
      alu_num1 = cur.load ? cur.a : acc;
      alu_num2 = cur.b;
      if (cur.op != OP_RSVD) begin
        alu_in_selector  = cur.load ? IN_LOAD : IN_PERSIST;
        alu_out_selector = out_sel_of(cur.op);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running  <= 1'b0;
      cur      <= '0;
      acc      <= 8'h00;
      wait_cnt <= 2'd0;
      res_data <= 8'h00;
      res_err  <= 1'b0;
    end else begin
      running <= 1'b1;
      if (pop) cur <= cmd_t'(fifo_rdata);
      if (state == S_ISSUE)     wait_cnt <= 2'd0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + 2'd1;
      // The reserved opcode reports an error and leaves the accumulator alone.
      if (capture) begin
        if (cur.op == OP_RSVD) begin
          res_data <= 8'h00;
          res_err  <= 1'b1;
        end else begin
          acc      <= alu_result;
          res_data <= alu_result;
          res_err  <= alu_overflow && (cur.op == OP_MULT);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer with a one-cycle ALU model
module tb_alu_op_sequencer;

  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic       cmd_load = 1'b0;
  logic [7:0] cmd_a = 8'h00;
  logic [7:0] cmd_b = 8'h00;
  logic       alu_on;
  logic [2:0] alu_in_selector;
  logic [7:0] alu_num1, alu_num2;
  logic [6:0] alu_out_selector;
  logic [7:0] alu_result = 8'h00;
  logic       alu_overflow = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       res_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int load_cnt = 0;
  int nz_cnt = 0;
  logic [6:0] last_out_sel = 7'd0;
  logic [2:0] last_in_sel = 3'd0;
  logic [7:0] last_num1 = 8'h00;
  logic [15:0] prod;
  logic [7:0] fill_exp [5] = '{8'h30, 8'hFC, 8'hF0, 8'h01, 8'hF0};

  alu_op_sequencer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_load(cmd_load),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_on(alu_on), .alu_in_selector(alu_in_selector), .alu_num1(alu_num1), .alu_num2(alu_num2),
    .alu_out_selector(alu_out_selector), .alu_result(alu_result), .alu_overflow(alu_overflow),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
  );

  always #5 clk = ~clk;

  assign prod = {8'h00, alu_num1} * {8'h00, alu_num2};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    alu_overflow <= 1'b0;
    case (alu_out_selector)
      7'b1000000: alu_result <= alu_num1 & alu_num2;
      7'b0100000: alu_result <= alu_num1 | alu_num2;
      7'b0010000: alu_result <= ~alu_num1;
      7'b0001000: alu_result <= alu_num1 ^ alu_num2;
      7'b0000100: alu_result <= alu_num1 + alu_num2;
      7'b0000010: alu_result <= alu_num1 - alu_num2;
      7'b0000001: begin alu_result <= prod[7:0]; alu_overflow <= |prod[15:8]; end
      default:    alu_result <= 8'h00;
    endcase
  end

  always @(negedge clk) begin
    if (alu_out_selector != 7'd0) begin
      last_out_sel <= alu_out_selector;
      last_in_sel  <= alu_in_selector;
      last_num1    <= alu_num1;
      nz_cnt       <= nz_cnt + 1;
    end
    if (alu_in_selector == 3'b010) load_cnt <= load_cnt + 1;
  end

  task automatic push(input logic [2:0] op, input logic load, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_load = load; cmd_a = a; cmd_b = b;
    while (cmd_ready !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    if (cmd_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL push_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (res_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    if (res_valid !== 1'b1) begin
      tests++; fails++;
      $display("FAIL %s_timeout: res_valid=%b required 1", tag, res_valid);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    if (cmd_ready !== 1'b0 || res_valid !== 1'b0 || alu_on !== 1'b0 || alu_in_selector !== 3'b001 ||
        alu_out_selector !== 7'd0 || alu_num1 !== 8'h00 || alu_num2 !== 8'h00 ||
        res_data !== 8'h00 || res_err !== 1'b0) begin
      fails++;
      $display("FAIL %s: rdy=%b vld=%b on=%b insel=%b outsel=%b n1=%h n2=%h data=%h err=%b required 0 0 0 001 0 00 00 00 0",
               tag, cmd_ready, res_valid, alu_on, alu_in_selector, alu_out_selector, alu_num1, alu_num2, res_data, res_err);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b1;
    #1;
    tests++;
    if (cmd_ready !== 1'b0) begin fails++; $display("FAIL ready_before_edge: cmd_ready=%b required 0", cmd_ready); end
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1 || alu_on !== 1'b1 || alu_in_selector !== 3'b100) begin
      fails++;
      $display("FAIL after_release: rdy=%b on=%b insel=%b required 1 1 100", cmd_ready, alu_on, alu_in_selector);
    end
  endtask

  task automatic test_chain_from_reset();
    res_ready = 1'b1;
    push(3'd2, 1'b0, 8'hEE, 8'h5A);
    wait_valid("chain0");
    tests++;
    if (res_data !== 8'h5A || last_num1 !== 8'h00) begin
      fails++; $display("FAIL chain0: data=%h num1=%h required 5a 00", res_data, last_num1);
    end
    @(negedge clk);
  endtask

  task automatic test_add();
    push(3'd4, 1'b1, 8'h05, 8'h03);
    wait_valid("add");
    tests++;
    if (res_data !== 8'h08 || res_err !== 1'b0) begin
      fails++; $display("FAIL add_data: data=%h err=%b required 08 0", res_data, res_err);
    end
    tests++;
    if (last_out_sel !== 7'b0000100 || last_in_sel !== 3'b010) begin
      fails++; $display("FAIL add_sel: outsel=%b insel=%b required 0000100 010", last_out_sel, last_in_sel);
    end
    @(negedge clk);
  endtask

  task automatic test_chain();
    push(3'd6, 1'b1, 8'h20, 8'h10);
    wait_valid("mult_ovf");
    tests++;
    if (res_data !== 8'h00 || res_err !== 1'b1) begin
      fails++; $display("FAIL mult_ovf: data=%h err=%b required 00 1", res_data, res_err);
    end
    @(negedge clk);
    push(3'd5, 1'b0, 8'h77, 8'h01);
    wait_valid("chain_sub");
    tests++;
    if (res_data !== 8'hFF || res_err !== 1'b0 || last_num1 !== 8'h00 || last_in_sel !== 3'b100) begin
      fails++; $display("FAIL chain_sub: data=%h err=%b num1=%h insel=%b required ff 0 00 100", res_data, res_err, last_num1, last_in_sel);
    end
    @(negedge clk);
    push(3'd4, 1'b0, 8'h00, 8'h02);
    wait_valid("chain_add");
    tests++;
    if (res_data !== 8'h01 || last_num1 !== 8'hFF) begin
      fails++; $display("FAIL chain_add: data=%h num1=%h required 01 ff", res_data, last_num1);
    end
    @(negedge clk);
    push(3'd6, 1'b0, 8'h00, 8'h03);
    wait_valid("chain_mult");
    tests++;
    if (res_data !== 8'h03 || res_err !== 1'b0) begin
      fails++; $display("FAIL chain_mult: data=%h err=%b required 03 0", res_data, res_err);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lb;
    int t_prev = 0;
    logic held;
    res_ready = 1'b0;
    push(3'd0, 1'b1, 8'hF0, 8'h3C);
    push(3'd1, 1'b1, 8'hF0, 8'h0C);
    push(3'd3, 1'b1, 8'h0F, 8'h99);
    push(3'd4, 1'b1, 8'hFF, 8'h02);
    push(3'd5, 1'b1, 8'h10, 8'h20);
    tests++;
    if (cmd_ready !== 1'b0) begin fails++; $display("FAIL fifo_full: cmd_ready=%b required 0", cmd_ready); end
    wait_valid("hold");
    tests++;
    if (res_data !== 8'h30) begin fails++; $display("FAIL hold_first: data=%h required 30", res_data); end
    lb = load_cnt;
    held = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== 8'h30) held = 1'b0;
    end
    tests++;
    if (held !== 1'b1) begin fails++; $display("FAIL hold_stable: vld=%b data=%h required 1 30", res_valid, res_data); end
    tests++;
    if (load_cnt != lb) begin fails++; $display("FAIL hold_load_pulses: got %0d required 0", load_cnt - lb); end
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid("drain");
      tests++;
      if (res_data !== fill_exp[i]) begin
        fails++; $display("FAIL drain_%0d: data=%h required %h", i, res_data, fill_exp[i]);
      end
      if (i > 0) begin
        tests++;
        if (cyc - t_prev != ALU_LAT + 2) begin
          fails++; $display("FAIL rate_%0d: spacing=%0d required %0d", i, cyc - t_prev, ALU_LAT + 2);
        end
      end
      t_prev = cyc;
      @(negedge clk);
    end
  endtask

  task automatic test_reserved();
    int nb;
    nb = nz_cnt;
    push(3'd7, 1'b1, 8'h12, 8'h34);
    wait_valid("rsvd");
    tests++;
    if (res_data !== 8'h00 || res_err !== 1'b1 || nz_cnt != nb) begin
      fails++; $display("FAIL rsvd: data=%h err=%b outsel_cycles=%0d required 00 1 0", res_data, res_err, nz_cnt - nb);
    end
    @(negedge clk);
    push(3'd4, 1'b0, 8'h00, 8'h01);
    wait_valid("rsvd_acc");
    tests++;
    if (res_data !== 8'hF1 || last_num1 !== 8'hF0) begin
      fails++; $display("FAIL rsvd_acc: data=%h num1=%h required f1 f0", res_data, last_num1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic seen;
    res_ready = 1'b1;
    push(3'd4, 1'b1, 8'h01, 8'h01);
    push(3'd4, 1'b1, 8'h02, 8'h02);
    push(3'd4, 1'b1, 8'h03, 8'h03);
    tests++;
    if (alu_out_selector !== 7'b0000100) begin
      fails++; $display("FAIL mid_inflight: outsel=%b required 0000100", alu_out_selector);
    end
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL mid_no_result: res_valid seen=%b required 0", seen); end
    push(3'd4, 1'b0, 8'h00, 8'h07);
    wait_valid("mid_chain");
    tests++;
    if (res_data !== 8'h07 || last_num1 !== 8'h00) begin
      fails++; $display("FAIL mid_chain: data=%h num1=%h required 07 00", res_data, last_num1);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_chain_from_reset();
    test_add();
    test_chain();
    test_back_to_back();
    test_reserved();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
